// File: rtl/gf2m_97_pkg.sv
// Shared constants and FSM state type for the GF(2^97) reducer
// (field polynomial x^97 + x^6 + 1).
package gf2m_97_pkg;
  localparam int M       = 97;
  localparam int K       = 6;
  localparam int PROD_W  = 2*M - 1;
  localparam int FOLD1_W = M - 1 + K;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FOLD2 = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/gf2m_fold_97.sv
// One combinational fold step: substitutes x^M = x^K + 1 for every bit at or
// above x^M. Output width is the larger of M and the shifted-high-part width.
module gf2m_fold_97
  import gf2m_97_pkg::*;
#(
  parameter int W  = PROD_W,
  parameter int OW = (M > W - M + K) ? M : W - M + K
) (
  input  logic [W-1:0]  x_i,
  output logic [OW-1:0] y_o
);

  always_comb begin
    y_o = '0;
    y_o[M-1:0] = x_i[M-1:0];
    // Each high coefficient x^(M+i) lands on x^i and x^(i+K).
    for (int i = 0; i < W - M; i++) begin
      y_o[i]     = y_o[i]     ^ x_i[M+i];
      y_o[i+K]   = y_o[i+K]   ^ x_i[M+i];
    end
  end

endmodule

// File: rtl/gf2m_reduce_97.sv
// Two-pass sequential reducer of a 193-bit carry-less product mod
// x^97 + x^6 + 1. Define GF2_RED_SKIP_EN to bypass folding when the product
// already has degree < 97.
module gf2m_reduce_97
  import gf2m_97_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      out_res
);

  state_e              state_q, state_d;
  logic [FOLD1_W-1:0]  r1_q, r1_d;
  logic [M-1:0]        r2_q, r2_d;
  logic [FOLD1_W-1:0]  fold1_y;
  logic [M-1:0]        fold2_y;

  gf2m_fold_97 #(.W(PROD_W), .OW(FOLD1_W)) u_fold1 (
    .x_i (in_prod),
    .y_o (fold1_y)
  );

  gf2m_fold_97 #(.W(FOLD1_W), .OW(M)) u_fold2 (
    .x_i (r1_q),
    .y_o (fold2_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    unique case (state_q)
      IDLE: begin
        // Registers load only on accept, so an undriven in_prod never enters state.
        if (in_valid) begin
`ifdef GF2_RED_SKIP_EN
          if (in_prod[PROD_W-1:M] == '0) begin
            r2_d    = in_prod[M-1:0];
            state_d = HOLD;
          end else begin
            r1_d    = fold1_y;
            state_d = FOLD2;
          end
`else
          r1_d    = fold1_y;
          state_d = FOLD2;
`endif
        end
      end
      FOLD2: begin
        r2_d    = fold2_y;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_res   = r2_q;

endmodule

// File: tb/tb_gf2m_reduce_97.sv
// Directed and randomized checks of gf2m_reduce_97 against hand-computed
// residues and a bitwise long-division reference.
module tb_gf2m_reduce_97;

`ifdef GF2_RED_SKIP_EN
  localparam int LAT_LOW = 1;
`else
  localparam int LAT_LOW = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [192:0] in_prod = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [96:0]  out_res;

  int ncmp  = 0;
  int nfail = 0;

  gf2m_reduce_97 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [192:0] clmul(input logic [96:0] a, input logic [96:0] b);
    logic [192:0] p = '0;
    for (int i = 0; i < 97; i++)
      if (b[i]) p = p ^ ({96'b0, a} << i);
    return p;
  endfunction

  // Long division from the top bit down, independent of the two-fold structure.
  function automatic logic [96:0] ref_reduce(input logic [192:0] p);
    logic [192:0] t = p;
    for (int i = 192; i >= 97; i--)
      if (t[i]) begin
        t[i]      = 1'b0;
        t[i-91]   = ~t[i-91];
        t[i-97]   = ~t[i-97];
      end
    return t[96:0];
  endfunction

  function automatic logic [192:0] xp(input int n);
    logic [192:0] v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic [96:0] rp(input int n);
    logic [96:0] v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic do_job(input logic [192:0] p, input logic [96:0] exp, input int exp_lat,
                        input bit chk_lat, input int hold_cyc, input string tag);
    int n;
    @(negedge clk);
    in_prod  = p;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (chk_lat) chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
    repeat (hold_cyc) begin @(posedge clk); #1; end
    chk(tag, 128'(out_res), 128'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (chk_lat) chk({tag, "_done"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [96:0]  ones;
    logic [127:0] w;
    logic [96:0]  a, b;
    logic [192:0] p;
    int n;
    ones = '1;

    // Reset and idle values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_res", 128'(out_res), 128'(0));
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    chk("idle_out_valid", 128'(out_valid), 128'(0));

    // Directed residues
    do_job(xp(97), 97'h41, 2, 1'b1, 0, "x97");
    do_job(xp(192), rp(95) | rp(10) | rp(4), 2, 1'b1, 0, "x192");
    do_job({96'b0, ones}, ones, LAT_LOW, 1'b1, 0, "low_ones");
    do_job(xp(102), 97'h820, 2, 1'b1, 0, "x102");
    do_job(xp(97) | xp(0), 97'h40, 2, 1'b1, 0, "x97p1");
    do_job(xp(96), rp(96), LAT_LOW, 1'b1, 0, "x96");
    do_job(xp(191), rp(94) | rp(9) | rp(3), 2, 1'b1, 0, "x191");

    // Backpressure: result stable, second request ignored
    @(negedge clk);
    in_prod = xp(192); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("bp_lat", 128'(n), 128'(2));
    in_prod = xp(97); in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_res", 128'(out_res), 128'(rp(95) | rp(10) | rp(4)));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_done_valid", 128'(out_valid), 128'(0));
    chk("bp_done_ready", 128'(in_ready), 128'(1));
    chk("bp_res_kept", 128'(out_res), 128'(rp(95) | rp(10) | rp(4)));
    repeat (3) @(posedge clk); #1;
    chk("bp_no_second", 128'(out_valid), 128'(0));

    // Reset while in FOLD2
    @(negedge clk);
    in_prod = xp(97); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy", 128'(in_ready), 128'(0));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_res", 128'(out_res), 128'(0));
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("mid_after_valid", 128'(out_valid), 128'(0));
    chk("mid_after_ready", 128'(in_ready), 128'(1));

    // Random products through the multiplier model with throttling
    for (int j = 0; j < 2000; j++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()}; a = w[96:0];
      w = {$urandom(), $urandom(), $urandom(), $urandom()}; b = w[96:0];
      p = clmul(a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_job(p, ref_reduce(p), 0, 1'b0, $urandom_range(0, 3), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
